// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Load/store has priority; a starvation counter bounds the fetch wait, and a tag pipeline steers read data back to its issuer.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT      = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_async_n,

    input  logic        if_req,
    input  logic [19:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [19:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,

    output logic        mem_en,
    output logic        mem_we,
    output logic [19:0] mem_address,
    output logic [31:0] mem_write_value,
    input  logic [31:0] mem_read_value,

    output logic [15:0] conflict_count
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0]         starve_cnt_q, starve_cnt_d;
    logic [MEM_LAT-1:0] tag_valid_q, tag_valid_d;
    logic [MEM_LAT-1:0] tag_owner_q, tag_owner_d;
    logic [15:0]        conflict_q, conflict_d;
    logic               fetch_prio;

    // Grants are gated by reset so the port is quiet while reset is held.
    always_comb begin
        fetch_prio      = (starve_cnt_q == STARVE_MAX);
        ls_gnt          = rst_async_n & ls_req & ~(if_req & fetch_prio);
        if_gnt          = rst_async_n & if_req & ~ls_gnt;
        mem_en          = if_gnt | ls_gnt;
        mem_we          = ls_gnt & ls_we;
        mem_address     = '0;
        mem_write_value = '0;
        if (ls_gnt) begin
            mem_address     = ls_addr;
            mem_write_value = ls_wdata;
        end else if (if_gnt) begin
            mem_address = if_addr;
        end
    end

    always_comb begin
        starve_cnt_d = '0;
        if (if_req && !if_gnt) begin
            starve_cnt_d = fetch_prio ? starve_cnt_q : starve_cnt_q + 4'd1;
        end
    end

    // Stores enter the tag pipe as invalid so they never raise an rvalid.
    always_comb begin
        tag_valid_d    = '0;
        tag_owner_d    = '0;
        tag_valid_d[0] = mem_en & ~mem_we;
        tag_owner_d[0] = ls_gnt;
        for (int i = 1; i < int'(MEM_LAT); i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_owner_d[i] = tag_owner_q[i-1];
        end
    end

    always_comb begin
        conflict_d = conflict_q;
        if (if_req && ls_req && conflict_q != 16'hFFFF) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            starve_cnt_q <= '0;
            tag_valid_q  <= '0;
            tag_owner_q  <= '0;
            conflict_q   <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            tag_valid_q  <= tag_valid_d;
            tag_owner_q  <= tag_owner_d;
            conflict_q   <= conflict_d;
        end
    end

    assign if_rvalid      = tag_valid_q[MEM_LAT-1] & ~tag_owner_q[MEM_LAT-1];
    assign ls_rvalid      = tag_valid_q[MEM_LAT-1] &  tag_owner_q[MEM_LAT-1];
    assign if_rdata       = mem_read_value;
    assign ls_rdata       = mem_read_value;
    assign conflict_count = conflict_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single 20-bit-address, 32-bit-data memory port between the instruction fetch stage and the load/store unit. Each requester presents a request and address and receives a same-cycle grant. A tag pipeline routes read data back to the requester that issued the read. Load/store has priority by default. A starvation counter bounds the fetch wait so the core cannot livelock on back-to-back data accesses.

## Interface
- MEM_LAT, 1, memory read latency in cycles (legal 1..4); mem_read_value is valid MEM_LAT cycles after the issuing cycle
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch takes priority (legal 1..15)

One clock; reset is asynchronous and active-low.
- clk  in  1  core clock, all state on rising edge
- rst_async_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch read request, held until if_gnt
- if_addr  in  20  fetch word address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  if_rdata valid this cycle
- if_rdata  out  32  fetch read data
- ls_req  in  1  load/store request, held until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  20  data word address
- ls_wdata  in  32  store data
- ls_gnt  out  1  load/store request accepted this cycle
- ls_rvalid  out  1  ls_rdata valid this cycle (loads only)
- ls_rdata  out  32  load read data
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write strobe
- mem_address  out  20  memory word address
- mem_write_value  out  32  memory write data
- mem_read_value  in  32  memory read data
- conflict_count  out  16  saturating count of cycles with both requests asserted

## Operation
- Arbitration is combinational from the requests and registered state:
  - If only one requester asserts req, it is granted.
  - If both assert req, ls wins unless starve_cnt == STARVE_LIMIT; then if wins.
- Exactly one gnt per cycle at most. mem_en = if_gnt | ls_gnt.
- Memory port outputs follow the winner:
  - mem_address = winner address.
  - mem_we = ls_gnt & ls_we.
  - mem_write_value = ls_wdata.
  - With no grant: mem_address = 0, mem_we = 0, mem_write_value = 0.
- starve_cnt (4 bits, registered):
  - Increments when if_req & !if_gnt.
  - Clears when if_gnt or !if_req.
  - Holds at STARVE_LIMIT; never exceeds it.
- Tag pipeline: MEM_LAT stages of {valid, owner}.
  - Stage 0 loads valid = mem_en & !mem_we, owner = ls_gnt (0 = fetch, 1 = ls).
  - Shifts every cycle.
  - Writes enter as invalid, so stores produce no rvalid.
- Return path, from the last tag stage:
  - if_rvalid = valid & !owner; ls_rvalid = valid & owner.
  - if_rdata and ls_rdata both equal mem_read_value. They are don't-care when the matching rvalid is 0.
- Reads return in issue order. Back-to-back reads, one per cycle, are supported with no bubbles.
- conflict_count increments when if_req & ls_req and saturates at 0xFFFF.

## Timing
- Reset (rst_async_n = 0) forces, immediately and asynchronously:
  - if_gnt = ls_gnt = 0, mem_en = mem_we = 0.
  - if_rvalid = ls_rvalid = 0.
  - All tag stages invalid, starve_cnt = 0, conflict_count = 0.
- Reset mid-operation discards every in-flight read. No rvalid is produced for those reads after release.
- Grant latency is 0 cycles: a request seen in cycle N is granted in cycle N unless it loses arbitration.
- Read latency: a read granted in cycle N gives rvalid in cycle N+MEM_LAT.
- Starvation bound, with both requests held continuously:
  - ls is granted cycles N..N+STARVE_LIMIT-1.
  - if is granted cycle N+STARVE_LIMIT.
  - The pattern then repeats.
- Dropping a req without a grant is illegal for requesters. The arbiter treats it as a withdrawal: no access is made and starve_cnt clears.
- A simultaneous ls store and if read resolves by the priority rule. The losing request stays pending, with no corruption of the store data.

## Test plan
- Reset then idle: rst_async_n low 3 cycles, then high, with no requests -> all outputs 0, conflict_count = 0, mem_en never 1.
- Single fetch, MEM_LAT=1, memory word 0x00010 = 0x1234_5678: if_req with if_addr = 0x00010 in cycle 5 -> if_gnt = 1 and mem_address = 0x00010 in cycle 5; if_rvalid = 1 and if_rdata = 0x1234_5678 in cycle 6.
- Contention, STARVE_LIMIT=4: both reqs held 10 cycles -> grant sequence ls,ls,ls,ls,if,ls,ls,ls,ls,if; conflict_count = 10.
- Store then load, same address: ls_we = 1, ls_addr = 0x000A0, ls_wdata = 0xDEAD_BEEF in cycle 2; load 0x000A0 in cycle 3 -> no ls_rvalid for the store; ls_rvalid with ls_rdata = 0xDEAD_BEEF at cycle 3+MEM_LAT.
- Interleaved reads, MEM_LAT=3: alternating if/ls reads over 6 cycles -> rvalids return on the correct side in issue order, each exactly 3 cycles after its grant.
- Reset mid-flight, MEM_LAT=3: fetch read granted in cycle 10, reset pulsed low in cycle 11 -> no if_rvalid in cycles 11-15.
